// File: rtl/bus_sequencer.sv
// Shared system-bus master. Each 16-clock period is split into a host slot (k0-k3),
// a video fetch slot (k4-k7) and a 6502 CPU slot (k8-k15). Every output is registered;
// next-state logic is keyed on the current slot so outputs change on the edge entering
// the slot in which they must be visible.
module bus_sequencer #(
  parameter logic [16:0] VRAM_BASE        = 17'h08000,
  // Must stay <= 12 so video fetches remain inside the 8000-8FFF window.
  parameter int unsigned VIDEO_ADDR_WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_req,
  input  logic [16:0]                 host_addr,
  input  logic                        host_we,
  input  logic [7:0]                  host_wdata,
  output logic [7:0]                  host_rdata,
  output logic                        host_done,
  input  logic [VIDEO_ADDR_WIDTH-1:0] video_addr,
  output logic [7:0]                  video_rdata,
  output logic                        video_valid,
  input  logic [15:0]                 cpu_addr,
  input  logic                        cpu_we,
  input  logic [7:0]                  cpu_wdata,
  output logic [7:0]                  cpu_rdata,
  output logic                        cpu_phi2,
  output logic [16:0]                 bus_addr,
  output logic                        bus_we,
  output logic [7:0]                  bus_wdata,
  input  logic [7:0]                  bus_rdata,
  output logic                        bus_strobe,
  output logic                        bus_is_cpu
);

  logic [3:0]  cnt_q, cnt_d;
  logic        host_active_q, host_active_d;
  logic [16:0] bus_addr_q, bus_addr_d;
  logic        bus_we_q, bus_we_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        bus_strobe_q, bus_strobe_d;
  logic        bus_is_cpu_q, bus_is_cpu_d;
  logic        cpu_phi2_q, cpu_phi2_d;
  logic        host_done_q, host_done_d;
  logic        video_valid_q, video_valid_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic [7:0]  video_rdata_q, video_rdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [16:0] video_bus_addr;

  assign video_bus_addr = VRAM_BASE + 17'(video_addr);

  // Next-state: decode the slot being left (cnt_q) to set up the slot being entered.
  always_comb begin
    cnt_d         = cnt_q + 4'd1;
    host_active_d = host_active_q;
    bus_addr_d    = bus_addr_q;
    bus_we_d      = bus_we_q;
    bus_wdata_d   = bus_wdata_q;
    bus_strobe_d  = 1'b0;
    bus_is_cpu_d  = cnt_d[3];
    cpu_phi2_d    = cnt_d[3];
    host_done_d   = 1'b0;
    video_valid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    video_rdata_d = video_rdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    case (cnt_q)
      // Only this sample of host_req matters; an idle slot keeps the old address.
      4'd15: begin
        host_active_d = host_req;
        bus_we_d      = host_req & host_we;
        if (host_req) begin
          bus_addr_d  = host_addr;
          bus_wdata_d = host_wdata;
        end
      end
      4'd0, 4'd1: bus_strobe_d = host_active_q;
      4'd2: begin
        host_done_d = host_active_q;
        if (host_active_q && !bus_we_q) host_rdata_d = bus_rdata;
      end
      4'd3: begin
        bus_addr_d = video_bus_addr;
        bus_we_d   = 1'b0;
      end
      4'd4, 4'd5: bus_strobe_d = 1'b1;
      4'd6: begin
        video_rdata_d = bus_rdata;
        video_valid_d = 1'b1;
      end
      4'd7: begin
        bus_addr_d = {1'b0, cpu_addr};
        bus_we_d   = cpu_we;
      end
      4'd11: begin
        bus_wdata_d  = cpu_wdata;
        bus_strobe_d = 1'b1;
      end
      4'd12, 4'd13: bus_strobe_d = 1'b1;
      4'd14: begin
        if (!bus_we_q) cpu_rdata_d = bus_rdata;
      end
      default: ;
    endcase
  end

  // State and output registers; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= 4'd0;
      host_active_q <= 1'b0;
      bus_addr_q    <= 17'd0;
      bus_we_q      <= 1'b0;
      bus_wdata_q   <= 8'd0;
      bus_strobe_q  <= 1'b0;
      bus_is_cpu_q  <= 1'b0;
      cpu_phi2_q    <= 1'b0;
      host_done_q   <= 1'b0;
      video_valid_q <= 1'b0;
      host_rdata_q  <= 8'd0;
      video_rdata_q <= 8'd0;
      cpu_rdata_q   <= 8'd0;
    end else begin
      cnt_q         <= cnt_d;
      host_active_q <= host_active_d;
      bus_addr_q    <= bus_addr_d;
      bus_we_q      <= bus_we_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_strobe_q  <= bus_strobe_d;
      bus_is_cpu_q  <= bus_is_cpu_d;
      cpu_phi2_q    <= cpu_phi2_d;
      host_done_q   <= host_done_d;
      video_valid_q <= video_valid_d;
      host_rdata_q  <= host_rdata_d;
      video_rdata_q <= video_rdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

  assign bus_addr    = bus_addr_q;
  assign bus_we      = bus_we_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_strobe  = bus_strobe_q;
  assign bus_is_cpu  = bus_is_cpu_q;
  assign cpu_phi2    = cpu_phi2_q;
  assign host_done   = host_done_q;
  assign video_valid = video_valid_q;
  assign host_rdata  = host_rdata_q;
  assign video_rdata = video_rdata_q;
  assign cpu_rdata   = cpu_rdata_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: a slot-level transaction model predicts every
// output each cycle, and directed phases add hand-computed literal expectations.
module tb_bus_sequencer;
  localparam logic [16:0] VRAM_BASE = 17'h08000;
  localparam int unsigned VW        = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_req, host_we;
  logic [16:0]   host_addr;
  logic [7:0]    host_wdata, host_rdata;
  logic          host_done;
  logic [VW-1:0] video_addr;
  logic [7:0]    video_rdata;
  logic          video_valid;
  logic [15:0]   cpu_addr;
  logic          cpu_we;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_phi2;
  logic [16:0]   bus_addr;
  logic          bus_we;
  logic [7:0]    bus_wdata, bus_rdata;
  logic          bus_strobe, bus_is_cpu;

  always #5 clk = ~clk;

  bus_sequencer #(.VRAM_BASE(VRAM_BASE), .VIDEO_ADDR_WIDTH(VW)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done),
    .video_addr(video_addr), .video_rdata(video_rdata), .video_valid(video_valid),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_phi2(cpu_phi2),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_strobe(bus_strobe), .bus_is_cpu(bus_is_cpu)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: slot number of the current period plus what each slot captured.
  logic        m_valid = 1'b0;
  int          m_k;
  logic        h_act, h_we, c_we;
  logic [16:0] h_addr, v_addr, c_addr;
  logic [7:0]  h_wdata, c_wdata, h_rdata, v_rdata, c_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_k     <= 0;
      h_act   <= 1'b0;
      h_we    <= 1'b0;
      c_we    <= 1'b0;
      c_addr  <= 17'd0;
      h_rdata <= 8'd0;
      v_rdata <= 8'd0;
      c_rdata <= 8'd0;
    end else if (m_valid) begin
      case (m_k)
        15: begin
          h_act <= host_req;
          if (host_req) begin
            h_addr  <= host_addr;
            h_we    <= host_we;
            h_wdata <= host_wdata;
          end
        end
        2:  if (h_act && !h_we) h_rdata <= bus_rdata;
        3:  v_addr <= VRAM_BASE + {6'd0, video_addr};
        6:  v_rdata <= bus_rdata;
        7: begin
          c_addr <= {1'b0, cpu_addr};
          c_we   <= cpu_we;
        end
        11: c_wdata <= cpu_wdata;
        14: if (!c_we) c_rdata <= bus_rdata;
        default: ;
      endcase
      m_k <= (m_k + 1) % 16;
    end
  end

  logic [16:0] e_addr;
  logic [7:0]  e_wdata;
  logic        e_we, e_strobe, e_cpu, e_done, e_valid;

  // Expected bus view for the slot currently on the bus.
  always_comb begin
    e_addr   = c_addr;
    e_wdata  = c_wdata;
    e_we     = 1'b0;
    e_strobe = 1'b0;
    e_cpu    = 1'b0;
    e_done   = 1'b0;
    e_valid  = 1'b0;
    if (m_k < 4) begin
      e_addr   = h_act ? h_addr : c_addr;
      e_wdata  = h_wdata;
      e_we     = h_act & h_we;
      e_strobe = h_act && (m_k == 1 || m_k == 2);
      e_done   = h_act && (m_k == 3);
    end else if (m_k < 8) begin
      e_addr   = v_addr;
      e_strobe = (m_k == 5 || m_k == 6);
      e_valid  = (m_k == 7);
    end else begin
      e_we     = c_we;
      e_strobe = (m_k >= 12 && m_k <= 14);
      e_cpu    = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("bus_addr", 32'(bus_addr), 32'(e_addr));
      chk("bus_we", 32'(bus_we), 32'(e_we));
      chk("bus_strobe", 32'(bus_strobe), 32'(e_strobe));
      chk("bus_is_cpu", 32'(bus_is_cpu), 32'(e_cpu));
      chk("cpu_phi2", 32'(cpu_phi2), 32'(e_cpu));
      chk("host_done", 32'(host_done), 32'(e_done));
      chk("video_valid", 32'(video_valid), 32'(e_valid));
      chk("host_rdata", 32'(host_rdata), 32'(h_rdata));
      chk("video_rdata", 32'(video_rdata), 32'(v_rdata));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(c_rdata));
      if (e_strobe && e_we) chk("bus_wdata", 32'(bus_wdata), 32'(e_wdata));
    end
  end

  // Advance to the cycle whose slot is k; sampled on the falling edge.
  task automatic wait_k(input int k);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_k == k) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_k timeout actual=none required=k%0d", k);
  endtask

  int n_strobe, n_phi, n_done;

  initial begin
    reset      = 1'b1;
    host_req   = 1'b0;
    host_addr  = 17'd0;
    host_we    = 1'b0;
    host_wdata = 8'd0;
    video_addr = '0;
    cpu_addr   = 16'd0;
    cpu_we     = 1'b0;
    cpu_wdata  = 8'd0;
    bus_rdata  = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_addr", 32'(bus_addr), 32'h0);
    chk("reset_phi2", 32'(cpu_phi2), 32'h0);
    reset = 1'b0;

    // Idle: two full periods of strobe/phi2 activity with no host traffic.
    n_strobe = 0;
    n_phi    = 0;
    n_done   = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_strobe += int'(bus_strobe);
      n_phi    += int'(cpu_phi2);
      n_done   += int'(host_done);
    end
    chk("idle_strobe_cycles", 32'(n_strobe), 32'd10);
    chk("idle_phi2_cycles", 32'(n_phi), 32'd16);
    chk("idle_host_done", 32'(n_done), 32'd0);

    // Host read.
    wait_k(10);
    host_req  = 1'b1;
    host_addr = 17'h0E810;
    host_we   = 1'b0;
    bus_rdata = 8'h5A;
    wait_k(0);
    chk("hrd_k0_addr", 32'(bus_addr), 32'h0E810);
    chk("hrd_k0_strobe", 32'(bus_strobe), 32'h0);
    wait_k(1);
    chk("hrd_k1_strobe", 32'(bus_strobe), 32'h1);
    wait_k(3);
    chk("hrd_done", 32'(host_done), 32'h1);
    chk("hrd_rdata", 32'(host_rdata), 32'h5A);
    host_req = 1'b0;

    // Host write.
    wait_k(10);
    host_req   = 1'b1;
    host_addr  = 17'h0F000;
    host_we    = 1'b1;
    host_wdata = 8'hA5;
    bus_rdata  = 8'h33;
    wait_k(1);
    chk("hwr_we", 32'(bus_we), 32'h1);
    chk("hwr_wdata", 32'(bus_wdata), 32'hA5);
    chk("hwr_is_cpu", 32'(bus_is_cpu), 32'h0);
    wait_k(3);
    chk("hwr_done", 32'(host_done), 32'h1);
    chk("hwr_rdata_kept", 32'(host_rdata), 32'h5A);
    host_req = 1'b0;
    host_we  = 1'b0;

    // Video fetch.
    wait_k(1);
    video_addr = 11'h3E7;
    bus_rdata  = 8'h20;
    wait_k(4);
    chk("vid_addr", 32'(bus_addr), 32'h083E7);
    wait_k(7);
    chk("vid_valid", 32'(video_valid), 32'h1);
    chk("vid_rdata", 32'(video_rdata), 32'h20);

    // CPU write then CPU read.
    cpu_addr  = 16'h8000;
    cpu_we    = 1'b1;
    cpu_wdata = 8'h41;
    wait_k(8);
    chk("cwr_addr", 32'(bus_addr), 32'h08000);
    chk("cwr_is_cpu", 32'(bus_is_cpu), 32'h1);
    chk("cwr_phi2", 32'(cpu_phi2), 32'h1);
    wait_k(12);
    chk("cwr_we", 32'(bus_we), 32'h1);
    chk("cwr_wdata", 32'(bus_wdata), 32'h41);
    chk("cwr_strobe", 32'(bus_strobe), 32'h1);
    wait_k(1);
    cpu_addr  = 16'hFFFC;
    cpu_we    = 1'b0;
    bus_rdata = 8'hEA;
    wait_k(15);
    chk("crd_rdata", 32'(cpu_rdata), 32'hEA);
    chk("crd_strobe_k15", 32'(bus_strobe), 32'h0);

    // Reset during k1 of a host read aborts it.
    wait_k(10);
    host_req  = 1'b1;
    host_addr = 17'h0E810;
    bus_rdata = 8'h77;
    wait_k(1);
    chk("rst_k1_strobe", 32'(bus_strobe), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_strobe", 32'(bus_strobe), 32'h0);
    chk("rst_done", 32'(host_done), 32'h0);
    chk("rst_host_rdata", 32'(host_rdata), 32'h0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    host_req = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_done += int'(host_done);
    end
    chk("rst_no_done", 32'(n_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
